// File: rtl/mfp_irq_ctrl_if.sv
// Register-bus and CPU acknowledge signals of the MFP interrupt controller.
// master = bus decoder / CPU side, slave = the controller.
interface mfp_irq_ctrl_if;
  logic       BUS_SEL;
  logic       BUS_WE;
  logic [3:0] BUS_ADDR;
  logic [7:0] BUS_DI;
  logic [7:0] BUS_DO;
  logic       IACK;
  logic       IRQ;
  logic [7:0] VEC;
  logic       VEC_VALID;

  modport master (
    output BUS_SEL, BUS_WE, BUS_ADDR, BUS_DI, IACK,
    input  BUS_DO, IRQ, VEC, VEC_VALID
  );

  modport slave (
    input  BUS_SEL, BUS_WE, BUS_ADDR, BUS_DI, IACK,
    output BUS_DO, IRQ, VEC, VEC_VALID
  );
endinterface

// File: rtl/mfp_irq_ctrl.sv
// MFP interrupt controller: 16 fixed-priority sources with IER/IPR/ISR/IMR/VR
// registers, registered IRQ and a three-state interrupt-acknowledge handshake.
module mfp_irq_ctrl (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [15:0]          SRC_PULSE,
  mfp_irq_ctrl_if.slave        bus
);

  typedef enum logic [1:0] {S_IDLE, S_VEC, S_HOLD} state_t;

  state_t      state, state_n;
  logic [15:0] ier, ipr, isr, imr;
  logic [15:0] ier_n, ipr_n, isr_n, imr_n;
  logic [7:0]  vr, vr_n;
  logic        iack_r, iack_rise;
  logic        k_valid;
  logic [3:0]  k;
  logic        ack_load, ack_do;
  logic [15:0] ack_clr, ack_set;
  logic [15:0] ipr_v, isr_v;
  logic [4:0]  act, isl;
  logic        irq_q, irq_n;
  logic [7:0]  vec_q, vec_now;
  logic [7:0]  do_q, rd_data;
  logic        wr_en;

  // {found, index} of the highest set bit
  function automatic logic [4:0] hi_idx(input logic [15:0] v);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++)
      if (v[i]) r = {1'b1, 4'(i)};
    return r;
  endfunction

  assign iack_rise = bus.IACK & ~iack_r;
  assign wr_en     = bus.BUS_SEL & bus.BUS_WE;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ack_load = 1'b0;
    ack_do   = 1'b0;
    unique case (state)
      S_IDLE: if (iack_rise) begin
        state_n  = S_VEC;
        ack_load = 1'b1;
      end
      S_VEC: begin
        state_n = S_HOLD;
        ack_do  = 1'b1;
      end
      S_HOLD: if (!bus.IACK) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Acknowledge effects applied to the registers in the VEC cycle
  always_comb begin
    ack_clr = '0;
    if (ack_do && k_valid) ack_clr = 16'(1) << k;
    ack_set = ack_clr & {16{vr_n[3]}};
  end

  always_comb begin
    ier_n = ier;
    ipr_n = ipr;
    isr_n = isr;
    imr_n = imr;
    vr_n  = vr;
    if (wr_en) begin
      case (bus.BUS_ADDR)
        4'd0: begin ier_n[15:8] = bus.BUS_DI; ipr_n[15:8] = ipr[15:8] & bus.BUS_DI; end
        4'd1: begin ier_n[7:0]  = bus.BUS_DI; ipr_n[7:0]  = ipr[7:0]  & bus.BUS_DI; end
        4'd2: ipr_n[15:8] = ipr[15:8] & bus.BUS_DI;
        4'd3: ipr_n[7:0]  = ipr[7:0]  & bus.BUS_DI;
        4'd4: isr_n[15:8] = isr[15:8] & bus.BUS_DI;
        4'd5: isr_n[7:0]  = isr[7:0]  & bus.BUS_DI;
        4'd6: imr_n[15:8] = bus.BUS_DI;
        4'd7: imr_n[7:0]  = bus.BUS_DI;
        4'd8: begin
          vr_n = bus.BUS_DI;
          if (!bus.BUS_DI[3]) isr_n = '0;
        end
        default: ;
      endcase
    end
    ipr_n = (ipr_n & ~ack_clr) | (SRC_PULSE & ier);
    isr_n = isr_n | ack_set;
  end

  // IRQ looks ahead through the acknowledge clear/set only, so it drops the
  // cycle after VEC while pulses and bus writes keep their two-cycle latency.
  always_comb begin
    ipr_v = ipr & ~ack_clr;
    isr_v = isr | ack_set;
    act   = hi_idx(ipr_v & imr);
    isl   = hi_idx(isr_v);
    irq_n = act[4] && (!isl[4] || (act[3:0] > isl[3:0]));
  end

  always_comb begin
    rd_data = '0;
    case (bus.BUS_ADDR)
      4'd0: rd_data = ier[15:8];
      4'd1: rd_data = ier[7:0];
      4'd2: rd_data = ipr[15:8];
      4'd3: rd_data = ipr[7:0];
      4'd4: rd_data = isr[15:8];
      4'd5: rd_data = isr[7:0];
      4'd6: rd_data = imr[15:8];
      4'd7: rd_data = imr[7:0];
      4'd8: rd_data = vr;
      default: rd_data = '0;
    endcase
  end

  assign vec_now = k_valid ? {vr[7:4], k} : 8'h18;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ier     <= '0;
      ipr     <= '0;
      isr     <= '0;
      imr     <= '0;
      vr      <= '0;
      iack_r  <= bus.IACK;   // a level held through reset is not an edge
      k_valid <= 1'b0;
      k       <= '0;
      irq_q   <= 1'b0;
      vec_q   <= '0;
      do_q    <= '0;
    end else begin
      ier    <= ier_n;
      ipr    <= ipr_n;
      isr    <= isr_n;
      imr    <= imr_n;
      vr     <= vr_n;
      iack_r <= bus.IACK;
      irq_q  <= irq_n;
      if (ack_load) begin
        k_valid <= irq_q & act[4];
        k       <= act[3:0];
      end
      if (state == S_VEC) vec_q <= vec_now;
      if (bus.BUS_SEL && !bus.BUS_WE) do_q <= rd_data;
    end
  end

  assign bus.IRQ       = irq_q;
  assign bus.VEC       = (state == S_VEC) ? vec_now : vec_q;
  assign bus.VEC_VALID = (state == S_VEC);
  assign bus.BUS_DO    = do_q;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Scoreboard bench for mfp_irq_ctrl: expected read data and vectors are queued
// by the stimulus and popped by a monitor when the DUT presents them.
module tb_mfp_irq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] SRC_PULSE = '0;

  mfp_irq_ctrl_if bus ();

  mfp_irq_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .SRC_PULSE (SRC_PULSE),
    .bus       (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] rd_q[$];
  logic [7:0] vec_q[$];
  logic       rd_flag = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor
  always @(posedge CLK) rd_flag <= bus.BUS_SEL && !bus.BUS_WE;

  always @(negedge CLK) begin
    if (rd_flag) begin
      if (rd_q.size() == 0) check("rd_queue", 16'(rd_q.size()), 16'd1);
      else check("bus_do", 16'(bus.BUS_DO), 16'(rd_q.pop_front()));
    end
    if (bus.VEC_VALID === 1'b1) begin
      if (vec_q.size() == 0) check("vec_unexpected", 16'(bus.VEC_VALID), 16'd0);
      else check("vec", 16'(bus.VEC), 16'(vec_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_p(input logic [3:0] a, input logic [7:0] d, input logic [15:0] p);
    bus.BUS_SEL = 1'b1; bus.BUS_WE = 1'b1; bus.BUS_ADDR = a; bus.BUS_DI = d;
    SRC_PULSE = p;
    tick();
    bus.BUS_SEL = 1'b0; bus.BUS_WE = 1'b0; SRC_PULSE = '0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_p(a, d, 16'h0000);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    rd_q.push_back(exp);
    bus.BUS_SEL = 1'b1; bus.BUS_WE = 1'b0; bus.BUS_ADDR = a;
    tick();
    bus.BUS_SEL = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] p);
    SRC_PULSE = p;
    tick();
    SRC_PULSE = '0;
  endtask

  task automatic chk_irq(input logic exp);
    check("irq", 16'(bus.IRQ), 16'(exp));
  endtask

  // IACK high for `hold` cycles; IRQ checked two cycles after the edge cycle
  task automatic ack(input logic [7:0] exp_vec, input logic exp_irq, input int hold);
    vec_q.push_back(exp_vec);
    bus.IACK = 1'b1;
    tick();
    tick();
    chk_irq(exp_irq);
    for (int i = 2; i < hold; i++) tick();
    bus.IACK = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.BUS_SEL = 1'b0; bus.BUS_WE = 1'b0; bus.BUS_ADDR = '0; bus.BUS_DI = '0;
    bus.IACK = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Reset state
    chk_irq(1'b0);
    check("rst_vec", 16'(bus.VEC), 16'h0000);
    check("rst_vec_valid", 16'(bus.VEC_VALID), 16'h0000);
    check("rst_bus_do", 16'(bus.BUS_DO), 16'h0000);
    rd(4'd0, 8'h00);
    rd(4'd8, 8'h00);

    // Timer A (source 13) basic flow
    wr(4'd0, 8'hFF); wr(4'd1, 8'hFF); wr(4'd6, 8'hFF); wr(4'd7, 8'hFF);
    wr(4'd8, 8'h40);
    rd(4'd0, 8'hFF);
    pulse(16'h2000);
    chk_irq(1'b0);
    tick();
    chk_irq(1'b1);
    rd(4'd2, 8'h20);
    ack(8'h4D, 1'b0, 3);
    rd(4'd2, 8'h00);

    // Software end-of-interrupt and in-service blocking
    wr(4'd8, 8'h48);
    pulse(16'h0020);
    tick();
    chk_irq(1'b1);
    ack(8'h45, 1'b0, 3);
    rd(4'd5, 8'h20);
    pulse(16'h0010);
    tick(); tick();
    chk_irq(1'b0);
    pulse(16'h0100);
    tick();
    chk_irq(1'b1);
    ack(8'h48, 1'b0, 3);
    rd(4'd4, 8'h01);
    wr(4'd5, 8'hDF);
    tick();
    chk_irq(1'b0);
    wr(4'd4, 8'hFE);
    chk_irq(1'b0);
    tick();
    chk_irq(1'b1);
    ack(8'h44, 1'b0, 3);
    rd(4'd5, 8'h10);
    wr(4'd8, 8'h40);
    rd(4'd5, 8'h00);

    // Simultaneous pulses: priority order
    pulse(16'h0204);
    tick();
    chk_irq(1'b1);
    ack(8'h49, 1'b1, 3);
    ack(8'h42, 1'b0, 3);
    rd(4'd3, 8'h00);
    rd(4'd2, 8'h00);

    // Masked source still pends
    wr(4'd6, 8'hFD);
    pulse(16'h0200);
    tick();
    chk_irq(1'b0);
    rd(4'd2, 8'h02);
    wr(4'd6, 8'hFF);
    chk_irq(1'b0);
    tick();
    chk_irq(1'b1);
    ack(8'h49, 1'b0, 3);

    // Spurious acknowledge, IACK held long: one strobe only
    ack(8'h18, 1'b0, 8);
    check("vec_hold", 16'(bus.VEC), 16'h0018);
    rd(4'd2, 8'h00);
    rd(4'd3, 8'h00);

    // Pulse beats a simultaneous IPR clear; IER clear discards pending
    pulse(16'h0002);
    wr_p(4'd3, 8'hFC, 16'h0001);
    rd(4'd3, 8'h01);
    wr(4'd1, 8'h00);
    pulse(16'h0001);
    rd(4'd3, 8'h00);
    wr(4'd1, 8'hFF);
    rd(4'd3, 8'h00);
    rd(4'd1, 8'hFF);

    // Reset during HOLD, IACK held through reset
    pulse(16'h0008);
    tick();
    chk_irq(1'b1);
    vec_q.push_back(8'h43);
    bus.IACK = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();
    chk_irq(1'b0);
    check("rst2_vec", 16'(bus.VEC), 16'h0000);
    check("rst2_vec_valid", 16'(bus.VEC_VALID), 16'h0000);
    check("rst2_bus_do", 16'(bus.BUS_DO), 16'h0000);
    for (int a = 0; a < 9; a++) rd(4'(a), 8'h00);
    rd(4'd12, 8'h00);
    repeat (3) tick();
    bus.IACK = 1'b0;
    repeat (3) tick();

    check("rd_q_drained", 16'(rd_q.size()), 16'd0);
    check("vec_q_drained", 16'(vec_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mfp_irq_ctrl.md
# mfp_irq_ctrl

Interrupt controller for the MFP: it collects one-cycle event pulses from the four timers and the other MFP sources, and holds the enable, pending, in-service and mask registers. It resolves fixed priority, drives the CPU interrupt request and returns the vector during an interrupt-acknowledge handshake. It sits between the timer/GPIP/USART event outputs and the MFP bus register decoder.

## Interface
- No parameters; 16 sources fixed, source 15 = highest priority, source 0 = lowest.
- CLK  in  1  system clock; every source pulse and bus access is synchronous to it.
- RST  in  1  reset, synchronous, active-high.
- SRC_PULSE  in  16  event pulses, one CLK wide per event (e.g. timer T_O_PULSE); bit n = source n.
- BUS_SEL  in  1  register access strobe, one cycle per access.
- BUS_WE  in  1  1 = write, 0 = read (qualified by BUS_SEL).
- BUS_ADDR  in  4  0 IERA, 1 IERB, 2 IPRA, 3 IPRB, 4 ISRA, 5 ISRB, 6 IMRA, 7 IMRB, 8 VR; 9-15 read 0, writes ignored.
- BUS_DI  in  8  write data. A registers = sources 15..8, B registers = sources 7..0.
- BUS_DO  out  8  registered read data.
- IACK  in  1  CPU interrupt acknowledge, level; an acknowledge is its rising edge.
- IRQ  out  1  registered interrupt request, active-high.
- VEC  out  8  acknowledged vector.
- VEC_VALID  out  1  one-cycle strobe qualifying VEC.

## Operation
- Reset: IER, IPR, ISR, IMR and VR are 0. IRQ=0, VEC=0, VEC_VALID=0, BUS_DO=0, state IDLE.
- Pending set: when SRC_PULSE[n]=1 and IER[n]=1, IPR[n] is set. A pulse with IER[n]=0 is discarded and is not remembered.
- IER write: the written value is stored. Every bit written 0 also clears the matching IPR bit.
- IPR write and ISR write: a 0 bit clears, a 1 bit leaves the bit unchanged.
- IMR and VR writes: plain store.
- IMR masks IRQ and vector selection only. Pending bits still set while masked.
- VR[7:4] = vector base. VR[3] = S (software end-of-interrupt). With S=0, ISR is never set. Clearing VR[3] by a write also clears all ISR bits.
- Active source: highest n with IPR[n]&IMR[n]=1.
- in-service level: highest n with ISR[n]=1, or -1 when ISR=0.
- IRQ = 1 when an active source exists and its priority is strictly greater than the in-service level.
- FSM states:
  - IDLE: on an IACK rising edge, latch the active index k (or "none" if IRQ=0), go to VEC.
  - VEC (one cycle): if k is valid, VEC={VR[7:4],k}, VEC_VALID=1, clear IPR[k], and set ISR[k] if S=1. If k is none, VEC=8'h18 (spurious), VEC_VALID=1, no register change. Go to HOLD.
  - HOLD: stay until IACK=0, then go to IDLE. IACK edges are not re-armed until release.
- Update order within one cycle: bus write, then the acknowledge clear/set, then the SRC_PULSE set. A pulse always wins over a simultaneous clear of the same IPR bit.
- Reads: BUS_DO returns the current register contents. IPR reads show pending bits regardless of IMR.

## Timing
- IACK edge detection uses a registered IACK_r; rising edge = IACK & ~IACK_r.
- SRC_PULSE at cycle t: IPR[n] is set at t+1, and IRQ rises at t+2.
- IACK goes high at cycle a: the FSM samples the edge in cycle a and is in VEC during a+1. VEC/VEC_VALID are valid in a+1, IPR/ISR update at the end of a+1, and IRQ reflects the new state at a+2.
- VEC holds its value until the next acknowledge. VEC_VALID is high exactly one cycle per acknowledge.
- Read: BUS_SEL&!BUS_WE at cycle r gives BUS_DO valid at r+1. A write at cycle w takes effect at w+1; IRQ reflects it at w+2.
- Reset mid-handshake: the FSM returns to IDLE, and the next cycle after reset deassertion needs a fresh IACK rising edge. An IACK held high through reset is not an edge.

## Test plan
- IER=0xFFFF, IMR=0xFFFF, pulse source 13 (timer A), VR=0x40: IRQ rises 2 cycles after the pulse. An IACK edge gives VEC=0x4D with VEC_VALID for one cycle. IPRA bit 5 clears and IRQ drops.
- S=1 (VR=0x48): acknowledge source 5 so ISRB bit 5 is set, then pulse source 4: IRQ stays 0. Pulse source 8: IRQ=1 and the acknowledge gives vector 0x48. Writing ISRB=0xDF then ISRA=0xFE re-enables the lower-priority request.
- Simultaneous pulses on sources 2 and 9: two acknowledges return 0x49 then 0x42, with IPRB/IPRA read back 0 afterwards.
- IMR bit 9 = 0, pulse 9: IPRA reads 0x02 and IRQ=0. Setting IMR bit 9 raises IRQ 2 cycles later.
- IACK edge with nothing pending: VEC=0x18 and no register change. Holding IACK high through several cycles yields exactly one VEC_VALID.
- Write IPRB=0xFE in the same cycle as a pulse on source 0: IPRB bit 0 remains 1. Assert RST during HOLD: all registers and outputs read 0.
